bist_ctrl: RTL and testbench

BIST_CTRL -- requirements
Module: bist_ctrl

---
 rtl/bist_ctrl_if.sv | 47 ++++
 rtl/bist_ctrl.sv | 148 ++++++++++++++
 tb/tb_bist_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_ctrl_if.sv
`timescale 1ns/1ps
// bist_ctrl_if: bus bundle between the BIST controller and its host/DUT side.
//   master : the controller (bist_ctrl). It takes the run requests, the seed
//            writes and the responses, and drives the pattern, status and signature.
//   slave  : the host and the circuit under test. This side drives the requests
//            and responses, and observes the pattern and status.
// Signals: start, seed_we, seed_in[W], resp_valid, resp_in[W] (to controller);
//          pattern[W], pattern_valid, busy, done, pass, signature[W] (from controller).
// Optional: abort, present only when BIST_ABORT_EN is defined.
interface bist_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic         seed_we;
  logic [W-1:0] seed_in;
  logic         resp_valid;
  logic [W-1:0] resp_in;
`ifdef BIST_ABORT_EN
  logic         abort;
`endif
  logic [W-1:0] pattern;
  logic         pattern_valid;
  logic         busy;
  logic         done;
  logic         pass;
  logic [W-1:0] signature;

`ifdef BIST_ABORT_EN
  modport master (
    input  start, seed_we, seed_in, resp_valid, resp_in, abort,
    output pattern, pattern_valid, busy, done, pass, signature
  );
  modport slave (
    output start, seed_we, seed_in, resp_valid, resp_in, abort,
    input  pattern, pattern_valid, busy, done, pass, signature
  );
`else
  modport master (
    input  start, seed_we, seed_in, resp_valid, resp_in,
    output pattern, pattern_valid, busy, done, pass, signature
  );
  modport slave (
    output start, seed_we, seed_in, resp_valid, resp_in,
    input  pattern, pattern_valid, busy, done, pass, signature
  );
`endif
endinterface

// File: rtl/bist_ctrl.sv
`timescale 1ns/1ps
// bist_ctrl: LFSR pattern generator plus MISR response compactor for logic BIST.
// A run loads the seed and issues PAT_CNT patterns. It then collects PAT_CNT
// responses or stops on a response timeout, and compares the signature with GOLDEN.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - bist_ctrl_if.master (start, seed write, responses in;
//            pattern, busy, done, pass, signature out)
// Optional feature macro BIST_ABORT_EN: adds bus.abort. When abort is high,
// the run returns to IDLE from any busy state.
//
// state | meaning
// IDLE  | waiting for start; seed register writable
// LOAD  | LFSR <- seed, MISR and counters cleared, pass cleared
// RUN   | one new pattern per cycle, PAT_CNT cycles
// DRAIN | waiting for outstanding responses, timeout armed
// CMP   | result latched into pass, done pulses
module bist_ctrl #(
  parameter int           W       = 16,
  parameter int           PAT_CNT = 1000,
  parameter logic [W-1:0] SEED    = W'(1),
  parameter logic [W-1:0] TAPS    = W'(16'h002D),
  parameter logic [W-1:0] GOLDEN  = '0,
  parameter int           TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  bist_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, CMP} state_t;

  localparam logic [19:0] PAT_N    = 20'(PAT_CNT);
  localparam logic [19:0] PAT_LAST = 20'(PAT_CNT - 1);
  localparam logic [7:0]  TMO_INIT = 8'(TIMEOUT);

  // Shift right and insert the XNOR feedback at the MSB.
  // The all-ones state is the one that locks up.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return {~^(s & TAPS), s[W-1:1]};
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] lfsr_q, lfsr_d;
  logic [W-1:0] seed_q, seed_d;
  logic [W-1:0] misr_q, misr_d;
  logic [19:0]  pcnt_q, pcnt_d;
  logic [19:0]  rcnt_q, rcnt_d;
  logic [7:0]   tmo_q, tmo_d;
  logic         pass_q, pass_d;
  logic         resp_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      seed_q  <= SEED;
      misr_q  <= '0;
      pcnt_q  <= '0;
      rcnt_q  <= '0;
      tmo_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      misr_q  <= misr_d;
      pcnt_q  <= pcnt_d;
      rcnt_q  <= rcnt_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    misr_d  = misr_q;
    pcnt_d  = pcnt_q;
    rcnt_d  = rcnt_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;

    // Responses count only while a run is collecting them, and only up to PAT_CNT.
    resp_take = bus.resp_valid && ((state_q == RUN) || (state_q == DRAIN)) &&
                (rcnt_q != PAT_N);
    if (resp_take) begin
      misr_d = lfsr_step(misr_q) ^ bus.resp_in;
      rcnt_d = rcnt_q + 20'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.seed_we) seed_d = (bus.seed_in == '1) ? SEED : bus.seed_in;
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        lfsr_d  = seed_q;
        misr_d  = '0;
        pcnt_d  = '0;
        rcnt_d  = '0;
        pass_d  = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        lfsr_d = lfsr_step(lfsr_q);
        pcnt_d = pcnt_q + 20'd1;
        if (pcnt_q == PAT_LAST) begin
          state_d = DRAIN;
          tmo_d   = TMO_INIT;
        end
      end
      DRAIN: begin
        // The count is registered, so the MISR is final when the compare happens.
        if (rcnt_q == PAT_N) begin
          state_d = CMP;
          pass_d  = (misr_q == GOLDEN);
        end else if (bus.resp_valid) begin
          tmo_d = TMO_INIT;
        end else if (tmo_q == 8'd1) begin
          state_d = CMP;
          pass_d  = 1'b0;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      CMP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef BIST_ABORT_EN
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end
`endif
  end

  assign bus.pattern       = lfsr_q;
  assign bus.pattern_valid = (state_q == RUN);
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == CMP);
  assign bus.pass          = pass_q;
  assign bus.signature     = misr_q;

endmodule

// File: tb/tb_bist_ctrl.sv
`timescale 1ns/1ps
module tb_bist_ctrl;

  typedef struct packed {
    logic pa;
    logic pb;
  } done_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   done_cyc = 0;
  int   last_resp_cyc = 0;
  int   echo_cnt = 0;
  int   echo_limit = 0;

  logic [15:0] exp_pat[$];
  done_exp_t   exp_done[$];

  logic        h1_v = 1'b0, h2_v = 1'b0;
  logic [15:0] h1_d = '0, h2_d = '0;

  bist_ctrl_if #(.W(16)) bus_a ();
  bist_ctrl_if #(.W(16)) bus_b ();

  // dut_a has the correct signature for echoed responses; dut_b is off by one bit.
  bist_ctrl #(.W(16), .PAT_CNT(4), .SEED(16'h0001), .TAPS(16'h002D),
              .GOLDEN(16'h5000), .TIMEOUT(8))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  bist_ctrl #(.W(16), .PAT_CNT(4), .SEED(16'h0001), .TAPS(16'h002D),
              .GOLDEN(16'h5001), .TIMEOUT(8))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_b.start      = bus_a.start;
  assign bus_b.seed_we    = bus_a.seed_we;
  assign bus_b.seed_in    = bus_a.seed_in;
  assign bus_b.resp_valid = bus_a.resp_valid;
  assign bus_b.resp_in    = bus_a.resp_in;
`ifdef BIST_ABORT_EN
  assign bus_b.abort      = bus_a.abort;
`endif

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Responses echo each pattern two cycles later, up to echo_limit of them.
  initial forever begin
    @(posedge clk);
    #1;
    if (reset) begin
      h1_v = 1'b0;
      h2_v = 1'b0;
      bus_a.resp_valid = 1'b0;
    end else begin
      bus_a.resp_valid = h2_v;
      bus_a.resp_in    = h2_d;
      if (h2_v) last_resp_cyc = cyc;
      h2_v = h1_v;
      h2_d = h1_d;
      h1_v = 1'b0;
      if (bus_a.pattern_valid && (echo_cnt < echo_limit)) begin
        h1_v = 1'b1;
        h1_d = bus_a.pattern;
        echo_cnt++;
      end
    end
  end

  // Monitor: pop and compare whenever either DUT presents a pattern or done.
  initial forever begin
    logic [15:0] ep;
    done_exp_t   ed;
    @(negedge clk);
    if (!reset) begin
      if (bus_a.pattern_valid || bus_b.pattern_valid) begin
        if (exp_pat.size() == 0) begin
          chk("pattern_valid_unexpected", {bus_a.pattern_valid, bus_b.pattern_valid}, 2'b00);
        end else begin
          ep = exp_pat.pop_front();
          chk("pattern_a", bus_a.pattern, ep);
          chk("pattern_valid_b", bus_b.pattern_valid, 1'b1);
          chk("pattern_b", bus_b.pattern, ep);
        end
      end
      if (bus_a.done || bus_b.done) begin
        n_done++;
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          chk("done_unexpected", {bus_a.done, bus_b.done}, 2'b00);
        end else begin
          ed = exp_done.pop_front();
          chk("done_a", bus_a.done, 1'b1);
          chk("done_b", bus_b.done, 1'b1);
          chk("pass_a", bus_a.pass, ed.pa);
          chk("pass_b", bus_b.pass, ed.pb);
        end
      end
    end
  end

  task automatic push4(input logic [15:0] p0, p1, p2, p3);
    exp_pat.push_back(p0);
    exp_pat.push_back(p1);
    exp_pat.push_back(p2);
    exp_pat.push_back(p3);
  endtask

  task automatic start_run(input logic we, input logic [15:0] sv, input int lim);
    echo_cnt   = 0;
    echo_limit = lim;
    bus_a.start   = 1'b1;
    bus_a.seed_we = we;
    bus_a.seed_in = sv;
    tick(1);
    bus_a.start   = 1'b0;
    bus_a.seed_we = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0 = n_done;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_done != n0) break;
    end
    #1;
    chk(name, n_done - n0, 1);
  endtask

  initial begin
    int n0;
    bus_a.start      = 1'b0;
    bus_a.seed_we    = 1'b0;
    bus_a.seed_in    = '0;
    bus_a.resp_valid = 1'b0;
    bus_a.resp_in    = '0;
`ifdef BIST_ABORT_EN
    bus_a.abort      = 1'b0;
`endif
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_pattern_valid", bus_a.pattern_valid, 1'b0);
    chk("rst_done", bus_a.done, 1'b0);
    chk("rst_pass", bus_a.pass, 1'b0);
    chk("rst_pattern", bus_a.pattern, 16'h0001);
    chk("rst_signature", bus_a.signature, 16'h0000);
    tick(1);

    // Default seed, full echo, extra start pulses in RUN must be ignored.
    push4(16'h0001, 16'h0000, 16'h8000, 16'hC000);
    exp_done.push_back('{pa: 1'b1, pb: 1'b0});
    start_run(1'b0, 16'h0000, 4);
    tick(1);
    bus_a.start = 1'b1;
    tick(2);
    bus_a.start = 1'b0;
    wait_done("wait_done_echo", 40);
    chk("sig_a_echo", bus_a.signature, 16'h5000);
    chk("sig_b_echo", bus_b.signature, 16'h5000);
    tick(3);
    chk("pass_hold_a", bus_a.pass, 1'b1);
    chk("busy_after_done", bus_a.busy, 1'b0);

    // seed_we together with start: the run uses the new seed; LOAD clears pass.
    push4(16'h1234, 16'h891A, 16'h448D, 16'h2246);
    exp_done.push_back('{pa: 1'b1, pb: 1'b0});
    start_run(1'b1, 16'h1234, 4);
    tick(1);
    chk("pass_cleared_by_load", bus_a.pass, 1'b0);
    wait_done("wait_done_seed", 40);
    tick(2);

    // All-ones seed is substituted; seed_we in RUN ignored; 3 responses -> timeout.
    bus_a.seed_we = 1'b1;
    bus_a.seed_in = 16'hFFFF;
    tick(1);
    bus_a.seed_we = 1'b0;
    push4(16'h0001, 16'h0000, 16'h8000, 16'hC000);
    exp_done.push_back('{pa: 1'b0, pb: 1'b0});
    start_run(1'b0, 16'h0000, 3);
    tick(1);
    bus_a.seed_we = 1'b1;
    bus_a.seed_in = 16'hABCD;
    tick(1);
    bus_a.seed_we = 1'b0;
    wait_done("wait_done_timeout", 60);
    chk("timeout_idle_cycles", done_cyc - last_resp_cyc - 1, 8);
    tick(2);

    // Seed still 0x0001; reset during RUN aborts with no done.
    exp_pat.push_back(16'h0001);
    exp_pat.push_back(16'h0000);
    n0 = n_done;
    start_run(1'b0, 16'h0000, 4);
    tick(2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrun_rst_busy", bus_a.busy, 1'b0);
    chk("midrun_rst_pattern_valid", bus_a.pattern_valid, 1'b0);
    chk("midrun_rst_done", bus_a.done, 1'b0);
    chk("midrun_rst_pass", bus_a.pass, 1'b0);
    chk("midrun_rst_signature", bus_a.signature, 16'h0000);
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("midrun_rst_no_done", n_done - n0, 0);

`ifdef BIST_ABORT_EN
    // Abort while waiting in DRAIN: idle next cycle, pass low, no done.
    push4(16'h0001, 16'h0000, 16'h8000, 16'hC000);
    n0 = n_done;
    start_run(1'b0, 16'h0000, 3);
    tick(6);
    chk("abort_pre_busy", bus_a.busy, 1'b1);
    chk("abort_pre_drain", bus_a.pattern_valid, 1'b0);
    bus_a.abort = 1'b1;
    tick(1);
    bus_a.abort = 1'b0;
    chk("abort_busy", bus_a.busy, 1'b0);
    chk("abort_pass", bus_a.pass, 1'b0);
    tick(20);
    chk("abort_no_done", n_done - n0, 0);
`endif

    tick(5);
    chk("pattern_queue_left", exp_pat.size(), 0);
    chk("done_queue_left", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
